io_slow_out_buffer: RTL and testbench

//  Downstream consumer of the slow-output decode (TYPE_PULSE, PUNCH_SIGNAL, MAG1..5_OUT).

---
 rtl/io_slow_out_buffer.sv | 135 +++++++++++++
 tb/tb_io_slow_out_buffer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_slow_out_buffer.sv
// Slow-output character buffer: captures strobed 5-bit codes into a small FIFO for the host
// and paces the TYPE (device-ready) handshake to mimic typewriter cycle time.
module io_slow_out_buffer #(
    parameter int DEPTH       = 4,
    parameter int CHAR_CYCLES = 16
) (
    input  logic                     CLK,
    input  logic                     rst,
    input  logic                     TYPE_PULSE,
    input  logic                     PUNCH_SIGNAL,
    input  logic                     MAG1_OUT,
    input  logic                     MAG2_OUT,
    input  logic                     MAG3_OUT,
    input  logic                     MAG4_OUT,
    input  logic                     MAG5_OUT,
    input  logic                     CLR_OVERRUN,
    input  logic                     OUT_READY,
    output logic                     TYPE,
    output logic                     OUT_VALID,
    output logic [4:0]               OUT_CODE,
    output logic                     OUT_PUNCH,
    output logic                     OVERRUN,
    output logic [$clog2(DEPTH):0]   FILL
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    localparam int CW = $clog2(CHAR_CYCLES + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    logic            type_pulse_q_reg;
    logic            strobe;
    logic            push;
    logic            drop;
    logic            pop;
    logic [5:0]      mem_reg [DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [FW-1:0]   fill_reg;
    logic [FW-1:0]   fill_next;
    state_t          state_reg;
    state_t          state_next;
    logic [CW-1:0]   count_reg;
    logic [CW-1:0]   count_next;
    logic            type_reg;
    logic            type_next;
    logic            overrun_reg;

    assign strobe    = TYPE_PULSE & ~type_pulse_q_reg;
    assign push      = strobe & type_reg;
    assign drop      = strobe & ~type_reg;
    assign OUT_VALID = (fill_reg != '0);
    assign pop       = OUT_VALID & OUT_READY;

    // Head is read combinationally so a captured character is visible the very next cycle.
    assign OUT_CODE  = OUT_VALID ? mem_reg[rd_ptr_reg][4:0] : 5'd0;
    assign OUT_PUNCH = OUT_VALID ? mem_reg[rd_ptr_reg][5]   : 1'b0;
    assign TYPE      = type_reg;
    assign OVERRUN   = overrun_reg;
    assign FILL      = fill_reg;

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= {PUNCH_SIGNAL, MAG5_OUT, MAG4_OUT, MAG3_OUT, MAG2_OUT, MAG1_OUT};
        end
    end

    always_comb begin
        fill_next = fill_reg;
        case ({push, pop})
            2'b10:   fill_next = fill_reg + FW'(1);
            2'b01:   fill_next = fill_reg - FW'(1);
            default: fill_next = fill_reg;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            type_pulse_q_reg <= 1'b0;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            fill_reg         <= '0;
            overrun_reg      <= 1'b0;
        end else begin
            type_pulse_q_reg <= TYPE_PULSE;
            if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            fill_reg <= fill_next;
            // A dropped strobe wins over a coincident clear.
            if (drop)             overrun_reg <= 1'b1;
            else if (CLR_OVERRUN) overrun_reg <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_reg <= IDLE;
            count_reg <= '0;
            type_reg  <= 1'b1;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            type_reg  <= type_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        case (state_reg)
            IDLE: begin
                count_next = '0;
                if (push) begin
                    state_next = BUSY;
                    count_next = CW'(CHAR_CYCLES);
                end
            end
            BUSY: begin
                count_next = count_reg - CW'(1);
                if (count_reg == CW'(1)) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    // TYPE is registered from next-cycle state and occupancy so it drops the cycle after a push.
    always_comb begin
        type_next = (state_next == IDLE) && (fill_next < FW'(DEPTH));
    end

endmodule

// File: tb/tb_io_slow_out_buffer.sv
// Self-checking bench for io_slow_out_buffer: directed scenarios plus randomized traffic
// compared cycle by cycle against a queue-based behavioural model.
module tb_io_slow_out_buffer;

    localparam int DEPTH       = 4;
    localparam int CHAR_CYCLES = 16;

    logic       CLK = 1'b0;
    logic       rst = 1'b0;
    logic       TYPE_PULSE = 1'b0;
    logic       PUNCH_SIGNAL = 1'b0;
    logic [4:0] mag = 5'd0;
    logic       CLR_OVERRUN = 1'b0;
    logic       OUT_READY = 1'b0;
    logic       TYPE;
    logic       OUT_VALID;
    logic [4:0] OUT_CODE;
    logic       OUT_PUNCH;
    logic       OVERRUN;
    logic [2:0] FILL;

    int checks = 0;
    int errors = 0;

    io_slow_out_buffer #(.DEPTH(DEPTH), .CHAR_CYCLES(CHAR_CYCLES)) dut (
        .CLK(CLK), .rst(rst), .TYPE_PULSE(TYPE_PULSE), .PUNCH_SIGNAL(PUNCH_SIGNAL),
        .MAG1_OUT(mag[0]), .MAG2_OUT(mag[1]), .MAG3_OUT(mag[2]), .MAG4_OUT(mag[3]),
        .MAG5_OUT(mag[4]), .CLR_OVERRUN(CLR_OVERRUN), .OUT_READY(OUT_READY),
        .TYPE(TYPE), .OUT_VALID(OUT_VALID), .OUT_CODE(OUT_CODE), .OUT_PUNCH(OUT_PUNCH),
        .OVERRUN(OVERRUN), .FILL(FILL)
    );

    always #5 CLK = ~CLK;

    wire [11:0] dut_vec = {TYPE, OUT_VALID, OUT_CODE, OUT_PUNCH, OVERRUN, FILL};

    // Behavioural model: queue of {punch, code}, a "busy until" cycle number, sticky overrun.
    logic [5:0] m_q[$];
    int         cyc = 0;
    int         busy_until = 0;
    bit         m_ovr = 0;
    bit         m_tp_q = 0;

    function automatic bit model_type();
        return (cyc >= busy_until) && (m_q.size() < DEPTH);
    endfunction

    function automatic logic [11:0] model_vec();
        logic [5:0] h;
        h = (m_q.size() != 0) ? m_q[0] : 6'd0;
        return {model_type(), m_q.size() != 0, h[4:0], h[5], m_ovr, 3'(m_q.size())};
    endfunction

    task automatic model_tick(input bit r, input bit t, input bit p, input logic [4:0] m,
                              input bit c, input bit y);
        bit ty;
        bit st;
        logic [5:0] h;
        if (r) begin
            m_q.delete();
            cyc = 0;
            busy_until = 0;
            m_ovr = 0;
            m_tp_q = 0;
        end else begin
            ty = model_type();
            st = t && !m_tp_q;
            if (y && m_q.size() != 0) begin
                h = m_q.pop_front();
                $display("pop  code=%b punch=%b", h[4:0], h[5]);
            end
            if (st && ty) begin
                m_q.push_back({p, m});
                busy_until = cyc + 1 + CHAR_CYCLES;
                $display("push code=%b punch=%b", m, p);
            end
            if (st && !ty) m_ovr = 1;
            else if (c)    m_ovr = 0;
            m_tp_q = t;
            cyc++;
        end
    endtask

    task automatic drive_cycle(input bit r, input bit t, input bit p, input logic [4:0] m,
                               input bit c, input bit y);
        rst = r;
        TYPE_PULSE = t;
        PUNCH_SIGNAL = p;
        mag = m;
        CLR_OVERRUN = c;
        OUT_READY = y;
        model_tick(r, t, p, m, c, y);
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_type(input bit y);
        for (int i = 0; i < 60 && TYPE !== 1'b1; i++) begin
            drive_cycle(0, 0, 0, 5'd0, 0, y);
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL wait_model got=%h exp=%h", dut_vec, model_vec());
            end
        end
        checks++;
        if (TYPE !== 1'b1) begin
            errors++;
            $display("FAIL wait_type_timeout TYPE=%b expected 1", TYPE);
        end
    endtask

    task automatic test_reset();
        drive_cycle(1, 0, 0, 5'd0, 0, 0);
        drive_cycle(1, 0, 0, 5'd0, 0, 0);
        checks++;
        if (dut_vec !== 12'b1_0_00000_0_0_000) begin
            errors++;
            $display("FAIL reset_state got=%h exp=%h", dut_vec, 12'b1_0_00000_0_0_000);
        end
        checks++;
        if (dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL reset_model got=%h exp=%h", dut_vec, model_vec());
        end
    endtask

    task automatic test_capture();
        int n;
        drive_cycle(0, 1, 0, 5'b10110, 0, 0);
        checks++;
        if (dut_vec !== 12'b0_1_10110_0_0_001) begin
            errors++;
            $display("FAIL capture_first got=%h exp=%h", dut_vec, 12'b0_1_10110_0_0_001);
        end
        n = 0;
        while (TYPE !== 1'b1 && n < 40) begin
            drive_cycle(0, 0, 0, 5'd0, 0, 0);
            n++;
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL capture_model got=%h exp=%h", dut_vec, model_vec());
            end
        end
        checks++;
        if (n != CHAR_CYCLES) begin
            errors++;
            $display("FAIL capture_pacing got=%0d cycles expected %0d", n, CHAR_CYCLES);
        end
        drive_cycle(0, 0, 0, 5'd0, 0, 1);
        checks++;
        if (FILL !== 3'd0 || OUT_VALID !== 1'b0) begin
            errors++;
            $display("FAIL capture_drain fill=%0d valid=%b expected 0 0", FILL, OUT_VALID);
        end
    endtask

    task automatic test_level_hold();
        logic [4:0] first;
        logic [4:0] m;
        wait_type(0);
        first = 5'($urandom);
        for (int i = 0; i < 40; i++) begin
            m = (i == 0) ? first : 5'($urandom);
            drive_cycle(0, 1, 1, m, 0, 0);
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL level_model got=%h exp=%h", dut_vec, model_vec());
            end
        end
        drive_cycle(0, 0, 0, 5'd0, 0, 0);
        checks++;
        if (FILL !== 3'd1 || OVERRUN !== 1'b0 || OUT_CODE !== first || OUT_PUNCH !== 1'b1) begin
            errors++;
            $display("FAIL level_hold fill=%0d ovr=%b code=%b punch=%b expected 1 0 %b 1",
                     FILL, OVERRUN, OUT_CODE, OUT_PUNCH, first);
        end
        drive_cycle(0, 0, 0, 5'd0, 0, 1);
    endtask

    task automatic test_full_overrun();
        for (int k = 1; k <= 4; k++) begin
            wait_type(0);
            drive_cycle(0, 1, 0, 5'(k), 0, 0);
            drive_cycle(0, 0, 0, 5'd0, 0, 0);
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL full_fill_model got=%h exp=%h", dut_vec, model_vec());
            end
        end
        for (int i = 0; i < 20; i++) drive_cycle(0, 0, 0, 5'd0, 0, 0);
        checks++;
        if (FILL !== 3'd4 || TYPE !== 1'b0) begin
            errors++;
            $display("FAIL full_hold fill=%0d type=%b expected 4 0", FILL, TYPE);
        end
        drive_cycle(0, 1, 0, 5'd5, 0, 0);
        checks++;
        if (OVERRUN !== 1'b1 || FILL !== 3'd4) begin
            errors++;
            $display("FAIL full_overrun ovr=%b fill=%0d expected 1 4", OVERRUN, FILL);
        end
        drive_cycle(0, 0, 0, 5'd0, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (OUT_VALID !== 1'b1 || OUT_CODE !== 5'(k)) begin
                errors++;
                $display("FAIL full_drain_order valid=%b code=%0d expected 1 %0d",
                         OUT_VALID, OUT_CODE, k);
            end
            drive_cycle(0, 0, 0, 5'd0, 0, 1);
        end
        checks++;
        if (FILL !== 3'd0) begin
            errors++;
            $display("FAIL full_drain_empty fill=%0d expected 0", FILL);
        end
        drive_cycle(0, 0, 0, 5'd0, 1, 0);
        checks++;
        if (OVERRUN !== 1'b0) begin
            errors++;
            $display("FAIL full_clear ovr=%b expected 0", OVERRUN);
        end
    endtask

    task automatic test_push_pop();
        wait_type(0);
        drive_cycle(0, 1, 1, 5'd7, 0, 0);
        drive_cycle(0, 0, 0, 5'd0, 0, 0);
        wait_type(0);
        drive_cycle(0, 1, 0, 5'd9, 0, 0);
        drive_cycle(0, 0, 0, 5'd0, 0, 0);
        wait_type(0);
        checks++;
        if (FILL !== 3'd2 || OUT_CODE !== 5'd7 || OUT_PUNCH !== 1'b1) begin
            errors++;
            $display("FAIL pp_setup fill=%0d code=%0d punch=%b expected 2 7 1",
                     FILL, OUT_CODE, OUT_PUNCH);
        end
        drive_cycle(0, 1, 0, 5'd11, 0, 1);
        checks++;
        if (FILL !== 3'd2 || OUT_CODE !== 5'd9 || dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL pp_simul got=%h exp=%h", dut_vec, model_vec());
        end
        drive_cycle(0, 0, 0, 5'd0, 0, 1);
        checks++;
        if (FILL !== 3'd1 || OUT_CODE !== 5'd11) begin
            errors++;
            $display("FAIL pp_order fill=%0d code=%0d expected 1 11", FILL, OUT_CODE);
        end
        drive_cycle(0, 0, 0, 5'd0, 0, 1);
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            wait_type(0);
            drive_cycle(0, 1, 0, 5'(20 + k), 0, 0);
            drive_cycle(0, 0, 0, 5'd0, 0, 0);
        end
        drive_cycle(0, 1, 0, 5'd30, 0, 0);
        drive_cycle(0, 0, 0, 5'd0, 0, 0);
        checks++;
        if (FILL !== 3'd3 || TYPE !== 1'b0 || OVERRUN !== 1'b1) begin
            errors++;
            $display("FAIL rmid_setup fill=%0d type=%b ovr=%b expected 3 0 1", FILL, TYPE, OVERRUN);
        end
        drive_cycle(1, 0, 0, 5'd0, 0, 0);
        checks++;
        if (dut_vec !== 12'b1_0_00000_0_0_000) begin
            errors++;
            $display("FAIL rmid_reset got=%h exp=%h", dut_vec, 12'b1_0_00000_0_0_000);
        end
    endtask

    task automatic test_clr_overrun();
        wait_type(0);
        drive_cycle(0, 1, 0, 5'd3, 0, 0);
        drive_cycle(0, 0, 0, 5'd0, 0, 0);
        drive_cycle(0, 1, 0, 5'd4, 1, 0);
        checks++;
        if (OVERRUN !== 1'b1 || FILL !== 3'd1) begin
            errors++;
            $display("FAIL clr_priority ovr=%b fill=%0d expected 1 1", OVERRUN, FILL);
        end
        drive_cycle(0, 0, 0, 5'd0, 0, 0);
        checks++;
        if (OVERRUN !== 1'b1) begin
            errors++;
            $display("FAIL clr_sticky ovr=%b expected 1", OVERRUN);
        end
        drive_cycle(0, 0, 0, 5'd0, 1, 1);
        checks++;
        if (OVERRUN !== 1'b0 || dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL clr_alone got=%h exp=%h", dut_vec, model_vec());
        end
    endtask

    task automatic test_random();
        bit t, c, y, p;
        for (int i = 0; i < 800; i++) begin
            t = ($urandom_range(0, 99) < 35);
            p = 1'($urandom);
            c = ($urandom_range(0, 19) == 0);
            y = ($urandom_range(0, 3) == 0);
            drive_cycle(0, t, p, 5'($urandom), c, y);
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL random_cycle%0d got=%h exp=%h", i, dut_vec, model_vec());
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_capture();
        test_level_hold();
        test_full_overrun();
        test_push_pop();
        test_reset_mid();
        test_clr_overrun();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout time=%0t limit=500000", $time);
        $fatal(1, "timeout");
    end

endmodule
